// File: rtl/flappy_bird_control_keycode_fifo_pkg.sv
// Shared constants for the keycode FIFO PIO:
// register offsets, STATUS/CTRL bit positions.
package flappy_bird_control_pkg;

    typedef enum logic [1:0] {
        KC_ADDR_LIVE   = 2'd0,
        KC_ADDR_POP    = 2'd1,
        KC_ADDR_STATUS = 2'd2,
        KC_ADDR_CTRL   = 2'd3
    } kc_addr_e;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_COUNT_LSB = 8;

    localparam int CTRL_IRQ_NE  = 0;
    localparam int CTRL_IRQ_OVF = 1;

    localparam int POP_VALID_BIT = 31;

    function automatic logic [31:0] status_word(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] w;
        w = '0;
        w[STATUS_EMPTY] = empty;
        w[STATUS_FULL]  = full;
        w[STATUS_OVF]   = ovf;
        w[STATUS_COUNT_LSB +: 8] = count;
        return w;
    endfunction

endpackage

// File: rtl/flappy_bird_control_keycode_fifo_if.sv
// Avalon-MM s1 slave bundle for the keycode FIFO PIO.
interface flappy_bird_control_keycode_fifo_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/flappy_bird_control_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is
// accepted only when a pop frees a slot on the same edge.
module flappy_bird_control_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    import flappy_bird_control_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flappy_bird_control_keycode_fifo.sv
// Keycode input PIO: synchronises in_port, queues each
// change in a FIFO, and raises a maskable level irq.
module flappy_bird_control_keycode_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PUSH_ZERO  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    flappy_bird_control_keycode_fifo_if.slave bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);
    import flappy_bird_control_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] head;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  rd;
    logic                  wr;
    logic                  ovf;
    logic                  ovf_set;
    logic                  ovf_clr;
    logic [1:0]            mask;
    logic [31:0]           rdata;
    logic                  unused_wdata;

    assign unused_wdata = ^bus.writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            cur   <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            cur   <= sync1;
            prev  <= cur;
        end
    end

    assign push = (cur != prev) &&
                  ((cur != '0) || (PUSH_ZERO != 0));

    assign rd  = bus.chipselect & bus.read;
    assign wr  = bus.chipselect & bus.write;
    assign pop = rd && (bus.address == KC_ADDR_POP);

    flappy_bird_control_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (cur),
        .dout    (head),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    // Full implies non-empty, so a POP read here always frees a slot.
    assign ovf_set = push & full & ~pop;
    assign ovf_clr = wr &&
                     (bus.address == KC_ADDR_STATUS) &&
                     bus.writedata[STATUS_OVF];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf  <= 1'b0;
            mask <= '0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (wr && (bus.address == KC_ADDR_CTRL)) begin
                mask <= bus.writedata[1:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (kc_addr_e'(bus.address))
            KC_ADDR_LIVE: begin
                rdata[DATA_WIDTH-1:0] = cur;
            end
            KC_ADDR_POP: begin
                if (!empty) begin
                    rdata[POP_VALID_BIT]  = 1'b1;
                    rdata[DATA_WIDTH-1:0] = head;
                end
            end
            KC_ADDR_STATUS: begin
                rdata = status_word(empty, full, ovf, 8'(count));
            end
            KC_ADDR_CTRL: begin
                rdata[1:0] = mask;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (rd) begin
                bus.readdata <= rdata;
            end
            irq <= (mask[CTRL_IRQ_NE] & ~empty) |
                   (mask[CTRL_IRQ_OVF] & ovf);
        end
    end

endmodule

// File: tb/tb_flappy_bird_control_keycode_fifo.sv
// Randomised scoreboard bench for the keycode FIFO PIO
// against a queue-based model of the register map.
module tb_flappy_bird_control_keycode_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PZ    = 0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_port;
    logic          irq;

    flappy_bird_control_keycode_fifo_if bus ();

    flappy_bird_control_keycode_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .PUSH_ZERO  (PZ)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];

    logic [DW-1:0] model_q [$];
    bit            m_ovf;
    bit [1:0]      m_mask;
    logic [DW-1:0] m_live;

    bit          rd_seen;
    logic [31:0] last_rd = '0;
    logic [31:0] mon_e;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_seen <= 1'b0;
        else rd_seen <= bus.chipselect & bus.read;
    end

    always @(negedge clk) begin
        if (rd_seen) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: readdata=%h, none expected",
                         bus.readdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.readdata !== mon_e) begin
                    miscompares++;
                    $display("FAIL readdata: got %h expected %h",
                             bus.readdata, mon_e);
                end
                last_rd = mon_e;
            end
        end else if (reset_n === 1'b1) begin
            vectors++;
            if (bus.readdata !== last_rd) begin
                miscompares++;
                $display("FAIL rd_hold: got %h expected %h",
                         bus.readdata, last_rd);
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0] = (model_q.size() == 0);
        s[1] = (model_q.size() == DEPTH);
        s[2] = m_ovf;
        s[15:8] = 8'(model_q.size());
        return s;
    endfunction

    function automatic logic [31:0] model_read(logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[DW-1:0] = m_live;
            2'd1: if (model_q.size() > 0) begin
                r[31] = 1'b1;
                r[DW-1:0] = model_q.pop_front();
            end
            2'd2: r = model_status();
            default: r[1:0] = m_mask;
        endcase
        return r;
    endfunction

    task automatic model_push(logic [DW-1:0] v);
        if (v != m_live && (v != 0 || PZ != 0)) begin
            if (model_q.size() == DEPTH) m_ovf = 1'b1;
            else model_q.push_back(v);
        end
        m_live = v;
    endtask

    task automatic bus_op(logic [1:0] a, bit r, bit w, logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read       = r;
        bus.write      = w;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
    endtask

    task automatic do_read(logic [1:0] a);
        exp_q.push_back(model_read(a));
        bus_op(a, 1'b1, 1'b0, '0);
        idle(1);
    endtask

    task automatic do_write(logic [1:0] a, logic [31:0] d);
        bus_op(a, 1'b0, 1'b1, d);
        if (a == 2'd2 && d[2]) m_ovf = 1'b0;
        if (a == 2'd3) m_mask = d[1:0];
        idle(1);
    endtask

    task automatic set_key(logic [DW-1:0] v);
        in_port = v;
        idle(4);
        model_push(v);
    endtask

    // POP read lands on the same edge as the push of v.
    task automatic push_pop(logic [DW-1:0] v);
        in_port = v;
        idle(2);
        exp_q.push_back(model_read(2'd1));
        bus_op(2'd1, 1'b1, 1'b0, '0);
        model_push(v);
        idle(2);
    endtask

    task automatic check_irq();
        bit e;
        e = (m_mask[0] && model_q.size() > 0) || (m_mask[1] && m_ovf);
        check("irq", 32'(irq), 32'(e));
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf  = 1'b0;
        m_mask = '0;
        m_live = '0;
    endtask

    task automatic pulse_reset();
        in_port = '0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        last_rd = '0;
        model_reset();
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    logic [DW-1:0] v;
    int            op;

    initial begin
        reset_n        = 1'b0;
        in_port        = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        model_reset();
        #1;
        check("init_readdata", bus.readdata, 32'h0);
        check("init_irq", 32'(irq), 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(1);

        do_read(2'd2);
        check_irq();

        set_key(8'h1A);
        do_read(2'd2);
        do_read(2'd0);
        do_read(2'd1);
        do_read(2'd1);

        set_key(8'h00);
        set_key(8'h1A);
        set_key(8'h00);
        set_key(8'h2C);
        repeat (3) do_read(2'd1);

        for (int i = 1; i <= 9; i++) set_key(DW'(i));
        do_read(2'd2);
        repeat (8) do_read(2'd1);
        do_read(2'd2);
        do_write(2'd2, 32'h4);
        do_read(2'd2);

        for (int i = 16; i < 24; i++) set_key(DW'(i));
        push_pop(8'h40);
        do_read(2'd2);
        repeat (9) do_read(2'd1);
        push_pop(8'h41);
        do_read(2'd2);

        do_write(2'd3, 32'h1);
        do_read(2'd3);
        check_irq();
        do_read(2'd1);
        check_irq();
        set_key(8'h55);
        check_irq();
        do_read(2'd1);
        check_irq();

        do_write(2'd3, 32'h2);
        for (int i = 1; i <= 9; i++) set_key(DW'(i + 32));
        check_irq();
        do_write(2'd2, 32'h4);
        check_irq();

        set_key(8'h61);
        set_key(8'h62);
        set_key(8'h63);
        pulse_reset();
        do_read(2'd2);
        check_irq();

        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 3) begin
                do v = DW'($urandom_range(0, 255));
                while (v == m_live);
                set_key(v);
            end else if (op <= 5) begin
                do_read(2'd1);
            end else if (op == 6) begin
                do_read(2'd2);
            end else if (op == 7) begin
                do_read($urandom_range(0, 1) ? 2'd0 : 2'd3);
            end else if (op == 8) begin
                do_write(2'($urandom_range(0, 3)), $urandom);
            end else begin
                do v = DW'($urandom_range(1, 255));
                while (v == m_live);
                push_pop(v);
            end
            check_irq();
        end

        idle(3);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
